// File: rtl/tx_pkg.sv
// Shared transmit-path definitions: symbol width, K28.5 commas and serializer state encoding.
package tx_pkg;

  localparam int unsigned SYM_W = 10;

  typedef logic [SYM_W-1:0] sym_t;

  // K28.5 comma in abcdei fghj order, bit 9 = a
  localparam sym_t K28_5_NEG = 10'b0011111010;
  localparam sym_t K28_5_POS = 10'b1100000101;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_DATA = 1'b1
  } tx_state_e;

endpackage

// File: rtl/tx_word_fifo.sv
// Small synchronous symbol FIFO with registered occupancy; read data is the current head.
module tx_word_fifo
  import tx_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic INTERCLK,
  input  logic Reset,
  input  logic push,
  input  logic pop,
  input  sym_t wdata,
  output sym_t rdata,
  output logic full,
  output logic empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  sym_t          mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge INTERCLK or posedge Reset) begin
    if (Reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge INTERCLK) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  assign rdata = mem[rd_ptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/tx_serializer.sv
// Parallel-to-serial stage after the 8b/10b encoder: MSB-first shifting with K28.5 fill
// of alternating disparity whenever the FIFO runs dry.
module tx_serializer
  import tx_pkg::*;
#(
  parameter int unsigned DEPTH    = 2,
  parameter sym_t        IDLE_NEG = K28_5_NEG,
  parameter sym_t        IDLE_POS = K28_5_POS
) (
  input  logic             INTERCLK,
  input  logic             Reset,
  input  logic [SYM_W-1:0] iData,
  input  logic             iValid,
  output logic             oReady,
  output logic             oSerial,
  output logic             oLoad,
  output logic             oIdle,
  output logic             oUnderrun
);

  localparam int unsigned       CNT_W    = 4;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(SYM_W - 1);

  tx_state_e        state_q, state_d;
  logic [CNT_W-1:0] bit_cnt_q;
  sym_t             shift_q;
  logic             phase_q, phase_d;
  logic             load;
  logic             push;
  logic             pop;
  logic             fifo_full;
  logic             fifo_empty;
  sym_t             fifo_head;
  sym_t             next_sym;
  logic             next_is_comma;
  logic             underrun_d;

  assign load   = (bit_cnt_q == LAST_BIT);
  assign oReady = ~Reset & ~fifo_full;
  assign push   = iValid & oReady;
  assign pop    = load & ~fifo_empty;

  tx_word_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .INTERCLK (INTERCLK),
    .Reset    (Reset),
    .push     (push),
    .pop      (pop),
    .wdata    (iData),
    .rdata    (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  // Symbol selection and FSM next state; only load edges can change anything
  always_comb begin
    state_d       = state_q;
    phase_d       = phase_q;
    next_sym      = fifo_head;
    next_is_comma = 1'b0;
    underrun_d    = 1'b0;
    if (load) begin
      if (!fifo_empty) begin
        state_d = ST_DATA;
      end else begin
        next_sym      = phase_q ? IDLE_POS : IDLE_NEG;
        next_is_comma = 1'b1;
        phase_d       = ~phase_q;
        underrun_d    = (state_q == ST_DATA);
        state_d       = ST_IDLE;
      end
    end
  end

  always_ff @(posedge INTERCLK or posedge Reset) begin
    if (Reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge INTERCLK or posedge Reset) begin
    if (Reset) begin
      bit_cnt_q <= LAST_BIT;
      shift_q   <= '0;
      phase_q   <= 1'b0;
      oLoad     <= 1'b0;
      oIdle     <= 1'b0;
      oUnderrun <= 1'b0;
    end else begin
      phase_q   <= phase_d;
      oLoad     <= load;
      oUnderrun <= underrun_d;
      if (load) begin
        bit_cnt_q <= '0;
        shift_q   <= next_sym;
        oIdle     <= next_is_comma;
      end else begin
        bit_cnt_q <= bit_cnt_q + CNT_W'(1);
        shift_q   <= {shift_q[SYM_W-2:0], 1'b0};
      end
    end
  end

  // The line bit is the MSB of the shift register, so it is a flop output
  assign oSerial = shift_q[SYM_W-1];

endmodule

// File: doc/tx_serializer.md
Name: tx_serializer

Overview:
- Transmit-side parallel-to-serial stage directly downstream of the 8b/10b encoder; consumes its 10-bit coded symbols ({a,b,c,d,e,i,f,g,h,j}, bit 9 = a).
- Buffers symbols in a small FIFO and shifts each one out one bit per clock, bit 9 (a) first.
- Inserts K28.5 comma symbols with alternating disparity whenever no coded symbol is available. Flags an underrun when the data stream breaks.

Parameters:
- DEPTH, 2, number of 10-bit entries in the input FIFO (power of two, >= 2).
- IDLE_NEG, 10'b0011111010, K28.5 comma with RD- (abcdei fghj).
- IDLE_POS, 10'b1100000101, K28.5 comma with RD+.

Ports:
- INTERCLK  in  1  bit-rate clock, rising edge active.
- Reset  in  1  asynchronous, active-high reset.
- iData  in  10  coded symbol from the encoder, bit 9 transmitted first.
- iValid  in  1  iData holds a symbol to accept.
- oReady  out  1  FIFO can accept a symbol this cycle.
- oSerial  out  1  serial line bit (registered).
- oLoad  out  1  high during the first bit of every symbol on oSerial.
- oIdle  out  1  high for all 10 bits while a comma is on oSerial.
- oUnderrun  out  1  one-cycle pulse, coincident with oLoad, when a comma follows a data symbol.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - oSerial=0, oLoad=0, oIdle=0, oUnderrun=0.
  - Shift register = 0, bit counter = 9, FIFO empty, comma phase = NEG, state = ST_IDLE.
  - oReady=0 while Reset is high.
- Reset mid-operation: the partial symbol and all FIFO contents are discarded. There is no completion of the current symbol.
- Accept: a push occurs on a rising edge when iValid && oReady. oReady = (FIFO occupancy < DEPTH), combinational from occupancy. iData is ignored when oReady=0, and the source must hold iData/iValid until accepted.
- Bit counter counts 0..9, incrementing every cycle.
- Load edge (counter==9):
  - Counter -> 0.
  - Shift register <- FIFO head if the FIFO is non-empty (pop). Otherwise it loads IDLE_NEG or IDLE_POS per the comma phase, and the phase toggles.
  - oLoad is registered high for the following cycle.
- Other edges: shift register shifts left by 1; oSerial = shift register bit 9.
- No bypass: a symbol pushed on a load edge is not popped on that edge. Minimum latency from push edge to its first bit on oSerial is 1 cycle (push at counter==8) and maximum is 10 cycles.
- Simultaneous push and pop on the same load edge is allowed. Occupancy is unchanged, the head is popped and the new entry is appended.
- When full, no push can occur (oReady=0). A pop frees a slot, and oReady rises in the next cycle.
- State machine, evaluated on load edges only:
  - ST_IDLE -> ST_DATA when a data symbol is loaded.
  - ST_DATA -> ST_IDLE when a comma is loaded; oUnderrun pulses with that load.
  - ST_IDLE stays in ST_IDLE while loading commas; there is no underrun pulse.
  - The first commas after reset do not flag underrun.
- oIdle is registered together with the shift-register load and held for 10 cycles.
- Comma disparity alternates NEG, POS, NEG, … across consecutive comma insertions and is not affected by data symbols. Data disparity is owned by the encoder.
- FIFO pointers are log2(DEPTH) bits and wrap modulo DEPTH. Occupancy is log2(DEPTH)+1 bits.

Decomposition:
- Shared package tx_pkg holds:
  - K28_5_NEG/K28_5_POS constants (shared with the encoder and the future comma detector).
  - SYM_W=10.
  - State encoding ST_IDLE/ST_DATA.
- Natural sub-module: tx_word_fifo (synchronous FIFO with push/pop, full/empty, occupancy, async active-high reset). The serializer holds the counter, the shift register and the FSM.

Test Plan:
- Reset release, iValid=0 for 30 cycles -> oSerial streams 0011111010, 1100000101, 0011111010. oIdle=1 throughout, oLoad every 10th cycle, oUnderrun never.
- Push 10'b1001110100 once after reset -> it appears MSB-first right after the current comma ends. oIdle=0 for those 10 bits, and a comma follows with a single oUnderrun pulse at its oLoad.
- Continuous iValid with symbols 0x2AA, 0x155, 0x3C0… -> back-to-back output with no commas between them. oReady toggles so that exactly one push occurs per 10 cycles at steady state.
- Fill the FIFO with 2 symbols while a comma shifts -> oReady=0 until the next load edge, high again one cycle later. No symbol is lost or duplicated.
- Push exactly on a load edge with the FIFO empty -> a comma is loaded on that edge and the symbol is sent in the next 10-bit slot.
- Assert Reset at bit 4 of a data symbol with 1 symbol queued -> outputs are 0 immediately. After release the first symbol is IDLE_NEG and the queued symbol never appears.
